// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the RV32I memory-access stage.
package mem_stage_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2,
        DONE = 2'd3
    } lsu_state_e;

    typedef struct packed {
        logic        valid;
        logic [31:0] alu_result;
        logic [31:0] rs2_data;
        logic        mem_read;
        logic        mem_write;
        logic [2:0]  funct3;
        logic [4:0]  rd;
        logic        reg_write;
        logic [1:0]  wb_sel;
        logic [31:0] pc;
    } ex_mem_bus_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] mem_data;
        logic [31:0] alu_result;
        logic [4:0]  rd;
        logic        reg_write;
        logic [1:0]  wb_sel;
        logic [31:0] pc;
    } mem_wb_bus_t;

    // Loads and stores decode funct3 differently: 100/101 are LBU/LHU but unknown for stores.
    function automatic logic [1:0] access_size(input logic [2:0] f3, input logic is_store);
        logic [1:0] sz;
        sz = SZ_W;
        if (is_store) begin
            case (f3)
                F3_B:    sz = SZ_B;
                F3_H:    sz = SZ_H;
                default: sz = SZ_W;
            endcase
        end else begin
            case (f3)
                F3_B, F3_BU: sz = SZ_B;
                F3_H, F3_HU: sz = SZ_H;
                default:     sz = SZ_W;
            endcase
        end
        return sz;
    endfunction

endpackage

// File: rtl/mem_stage_lsu_align.sv
// Combinational store-lane steering, load extraction/extension and alignment check.
module mem_stage_lsu_align
    import mem_stage_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int STRB_W = XLEN / 8
) (
    input  logic [1:0]        byte_off,
    input  logic [2:0]        funct3,
    input  logic              is_store,
    input  logic [XLEN-1:0]   rs2_data,
    input  logic [XLEN-1:0]   rdata,
    output logic [STRB_W-1:0] wstrb,
    output logic [XLEN-1:0]   wdata,
    output logic [XLEN-1:0]   load_data,
    output logic              misaligned
);

    logic [1:0]      size_s;
    logic [XLEN-1:0] shifted_s;

    // Store lanes and alignment check by access size.
    always_comb begin
        size_s = access_size(funct3, is_store);
        case (size_s)
            SZ_B: begin
                wstrb      = 4'b0001 << byte_off;
                wdata      = {4{rs2_data[7:0]}};
                misaligned = 1'b0;
            end
            SZ_H: begin
                wstrb      = 4'b0011 << byte_off;
                wdata      = {2{rs2_data[15:0]}};
                misaligned = byte_off[0];
            end
            default: begin
                wstrb      = 4'b1111;
                wdata      = rs2_data;
                misaligned = |byte_off;
            end
        endcase
    end

    // Load lane extraction with sign or zero extension.
    always_comb begin
        shifted_s = rdata >> {byte_off, 3'b000};
        case (funct3)
            F3_B:    load_data = {{(XLEN-8){shifted_s[7]}}, shifted_s[7:0]};
            F3_BU:   load_data = {{(XLEN-8){1'b0}}, shifted_s[7:0]};
            F3_H:    load_data = {{(XLEN-16){shifted_s[15]}}, shifted_s[15:0]};
            F3_HU:   load_data = {{(XLEN-16){1'b0}}, shifted_s[15:0]};
            default: load_data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// RV32I memory stage: issues data-memory accesses, stalls until complete, feeds MEM/WB.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int STRB_W = XLEN / 8
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  ex_mem_bus_t       ex_mem_bus_in,
    input  logic              stall_in,
    output logic              mem_stall_req,
    output logic              dmem_req_valid,
    input  logic              dmem_req_ready,
    output logic [XLEN-1:0]   dmem_req_addr,
    output logic              dmem_req_we,
    output logic [STRB_W-1:0] dmem_req_wstrb,
    output logic [XLEN-1:0]   dmem_req_wdata,
    input  logic              dmem_rsp_valid,
    input  logic [XLEN-1:0]   dmem_rsp_rdata,
    output mem_wb_bus_t       mem_wb_bus_out,
    output logic              misaligned,
    output logic [XLEN-1:0]   misaligned_addr
);

    lsu_state_e        state_r;
    lsu_state_e        next_state_s;
    logic [XLEN-1:0]   load_buf_r;
    logic              access_s;
    logic              is_store_s;
    logic              align_mis_s;
    logic              mis_s;
    logic              req_s;
    logic              stall_s;
    logic [XLEN-1:0]   mem_data_s;
    logic [STRB_W-1:0] wstrb_s;
    logic [XLEN-1:0]   wdata_s;
    logic [XLEN-1:0]   load_data_s;

    assign access_s   = ex_mem_bus_in.valid & (ex_mem_bus_in.mem_read | ex_mem_bus_in.mem_write);
    assign is_store_s = ex_mem_bus_in.mem_write;
    assign mis_s      = access_s & align_mis_s;

    mem_stage_lsu_align #(.XLEN(XLEN), .STRB_W(STRB_W)) u_align (
        .byte_off   (ex_mem_bus_in.alu_result[1:0]),
        .funct3     (ex_mem_bus_in.funct3),
        .is_store   (is_store_s),
        .rs2_data   (ex_mem_bus_in.rs2_data),
        .rdata      (dmem_rsp_rdata),
        .wstrb      (wstrb_s),
        .wdata      (wdata_s),
        .load_data  (load_data_s),
        .misaligned (align_mis_s)
    );

    // Load/store FSM: request issue, stall generation and next-state selection.
    always_comb begin
        next_state_s = state_r;
        req_s        = 1'b0;
        stall_s      = 1'b0;
        mem_data_s   = '0;
        case (state_r)
            IDLE, REQ: begin
                if ((state_r == REQ) || (access_s && !mis_s)) begin
                    req_s   = 1'b1;
                    stall_s = !(is_store_s && dmem_req_ready);
                    if (!dmem_req_ready) begin
                        next_state_s = REQ;
                    end else if (is_store_s) begin
                        next_state_s = stall_in ? DONE : IDLE;
                    end else begin
                        next_state_s = RSP;
                    end
                end else begin
                    next_state_s = IDLE;
                end
            end
            RSP: begin
                if (dmem_rsp_valid) begin
                    mem_data_s   = load_data_s;
                    next_state_s = stall_in ? DONE : IDLE;
                end else begin
                    stall_s = 1'b1;
                end
            end
            DONE: begin
                mem_data_s   = is_store_s ? '0 : load_buf_r;
                next_state_s = stall_in ? DONE : IDLE;
            end
            default: next_state_s = IDLE;
        endcase
    end

    // Output drive; everything reads zero while reset is held.
    always_comb begin
        mem_wb_bus_out = '0;
        if (ARESET) begin
            mem_stall_req   = 1'b0;
            dmem_req_valid  = 1'b0;
            dmem_req_we     = 1'b0;
            dmem_req_wstrb  = '0;
            misaligned      = 1'b0;
            misaligned_addr = '0;
        end else begin
            mem_stall_req             = stall_s;
            dmem_req_valid            = req_s;
            dmem_req_we               = req_s & is_store_s;
            dmem_req_wstrb            = (req_s & is_store_s) ? wstrb_s : '0;
            misaligned                = (state_r == IDLE) & mis_s;
            misaligned_addr           = ((state_r == IDLE) & mis_s) ? ex_mem_bus_in.alu_result : '0;
            mem_wb_bus_out.valid      = ex_mem_bus_in.valid;
            mem_wb_bus_out.mem_data   = mem_data_s;
            mem_wb_bus_out.alu_result = ex_mem_bus_in.alu_result;
            mem_wb_bus_out.rd         = ex_mem_bus_in.rd;
            mem_wb_bus_out.reg_write  = ex_mem_bus_in.reg_write & ~mis_s;
            mem_wb_bus_out.wb_sel     = ex_mem_bus_in.wb_sel;
            mem_wb_bus_out.pc         = ex_mem_bus_in.pc;
        end
    end

    assign dmem_req_addr  = {ex_mem_bus_in.alu_result[XLEN-1:2], 2'b00};
    assign dmem_req_wdata = wdata_s;

    // State register and load buffer; buffer captures only a pending response.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_r    <= IDLE;
            load_buf_r <= '0;
        end else begin
            state_r <= next_state_s;
            if ((state_r == RSP) && dmem_rsp_valid) begin
                load_buf_r <= load_data_s;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage: vector tables plus multi-cycle sequences.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic        ACLK = 1'b0;
    logic        ARESET;
    ex_mem_bus_t em;
    logic        stall_in;
    logic        mem_stall_req;
    logic        dmem_req_valid;
    logic        dmem_req_ready;
    logic [31:0] dmem_req_addr;
    logic        dmem_req_we;
    logic [3:0]  dmem_req_wstrb;
    logic [31:0] dmem_req_wdata;
    logic        dmem_rsp_valid;
    logic [31:0] dmem_rsp_rdata;
    mem_wb_bus_t wb;
    logic        misaligned;
    logic [31:0] misaligned_addr;

    int checks = 0;
    int failures = 0;

    mem_stage dut (
        .ACLK(ACLK), .ARESET(ARESET), .ex_mem_bus_in(em), .stall_in(stall_in),
        .mem_stall_req(mem_stall_req), .dmem_req_valid(dmem_req_valid),
        .dmem_req_ready(dmem_req_ready), .dmem_req_addr(dmem_req_addr),
        .dmem_req_we(dmem_req_we), .dmem_req_wstrb(dmem_req_wstrb),
        .dmem_req_wdata(dmem_req_wdata), .dmem_rsp_valid(dmem_rsp_valid),
        .dmem_rsp_rdata(dmem_rsp_rdata), .mem_wb_bus_out(wb),
        .misaligned(misaligned), .misaligned_addr(misaligned_addr)
    );

    always #5 ACLK = ~ACLK;

    typedef struct {
        logic        valid, rd_en, wr_en, rw, ready;
        logic [2:0]  f3;
        logic [31:0] addr, rs2;
        logic        e_req, e_stall, e_mis, e_rw;
        logic [3:0]  e_strb;
        logic [31:0] e_wdata, e_addr;
    } vec_t;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] addr, rdata, e_data;
    } ld_t;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic rd_en, input logic wr_en, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] rs2, input logic rw);
        em.valid = v; em.mem_read = rd_en; em.mem_write = wr_en; em.funct3 = f3;
        em.alu_result = addr; em.rs2_data = rs2; em.reg_write = rw;
        em.rd = 5'd7; em.wb_sel = 2'd1; em.pc = 32'h0000_1000;
    endtask

    task automatic bubble();
        drive(1'b0, 1'b0, 1'b0, F3_W, 32'h0, 32'h0, 1'b0);
        dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0; stall_in = 1'b0;
    endtask

    vec_t vt[11];
    ld_t  lt[5];
    int   n_stall, n_req;

    initial begin
        //        valid rd wr  rw ready f3     addr          rs2           req stall mis rw strb     wdata         addr
        vt[0]  = '{1'b1,1'b0,1'b1,1'b0,1'b1,F3_W, 32'h104,32'hDEADBEEF,1'b1,1'b0,1'b0,1'b0,4'b1111,32'hDEADBEEF,32'h104};
        vt[1]  = '{1'b1,1'b0,1'b1,1'b0,1'b1,F3_H, 32'h102,32'hAAAA5555,1'b1,1'b0,1'b0,1'b0,4'b1100,32'h55555555,32'h100};
        vt[2]  = '{1'b1,1'b0,1'b1,1'b0,1'b1,F3_B, 32'h101,32'h12345678,1'b1,1'b0,1'b0,1'b0,4'b0010,32'h78787878,32'h100};
        vt[3]  = '{1'b1,1'b0,1'b1,1'b0,1'b1,F3_B, 32'h103,32'h000000A5,1'b1,1'b0,1'b0,1'b0,4'b1000,32'hA5A5A5A5,32'h100};
        vt[4]  = '{1'b1,1'b0,1'b1,1'b0,1'b1,F3_H, 32'h100,32'h0000BEEF,1'b1,1'b0,1'b0,1'b0,4'b0011,32'hBEEFBEEF,32'h100};
        vt[5]  = '{1'b1,1'b0,1'b1,1'b0,1'b1,3'b111,32'h108,32'h01020304,1'b1,1'b0,1'b0,1'b0,4'b1111,32'h01020304,32'h108};
        vt[6]  = '{1'b1,1'b1,1'b0,1'b1,1'b1,F3_W, 32'h101,32'h0,       1'b0,1'b0,1'b1,1'b0,4'b0000,32'h0,       32'h100};
        vt[7]  = '{1'b1,1'b1,1'b0,1'b1,1'b1,F3_H, 32'h203,32'h0,       1'b0,1'b0,1'b1,1'b0,4'b0000,32'h0,       32'h200};
        vt[8]  = '{1'b1,1'b0,1'b1,1'b0,1'b1,F3_W, 32'h102,32'h0,       1'b0,1'b0,1'b1,1'b0,4'b0000,32'h0,       32'h100};
        vt[9]  = '{1'b1,1'b0,1'b0,1'b1,1'b1,F3_W, 32'h1234,32'h0,      1'b0,1'b0,1'b0,1'b1,4'b0000,32'h0,       32'h1234};
        vt[10] = '{1'b0,1'b1,1'b0,1'b0,1'b1,F3_W, 32'h300,32'h0,       1'b0,1'b0,1'b0,1'b0,4'b0000,32'h0,       32'h300};

        lt[0] = '{F3_HU, 32'h202, 32'h80FF1234, 32'h000080FF};
        lt[1] = '{F3_H,  32'h202, 32'h80FF1234, 32'hFFFF80FF};
        lt[2] = '{F3_BU, 32'h201, 32'h00008000, 32'h00000080};
        lt[3] = '{F3_W,  32'h204, 32'h89ABCDEF, 32'h89ABCDEF};
        lt[4] = '{3'b011,32'h208, 32'h13572468, 32'h13572468};

        // Reset held with an aligned store presented: everything must read zero.
        ARESET = 1'b1; bubble();
        drive(1'b1, 1'b0, 1'b1, F3_W, 32'h104, 32'hDEADBEEF, 1'b1);
        dmem_req_ready = 1'b1;
        repeat (2) @(posedge ACLK);
        @(negedge ACLK); #1;
        chk("rst_req_valid", dmem_req_valid, 1'b0);
        chk("rst_stall", mem_stall_req, 1'b0);
        chk("rst_misaligned", misaligned, 1'b0);
        chk("rst_wb_bus", wb, '0);
        chk("rst_state", 32'(dut.state_r), 32'(IDLE));
        @(negedge ACLK); ARESET = 1'b0; bubble();

        // Single-cycle vector table, each applied from IDLE.
        for (int i = 0; i < 11; i++) begin
            @(negedge ACLK);
            drive(vt[i].valid, vt[i].rd_en, vt[i].wr_en, vt[i].f3, vt[i].addr, vt[i].rs2, vt[i].rw);
            dmem_req_ready = vt[i].ready;
            #1;
            chk($sformatf("v%0d_req_valid", i), dmem_req_valid, vt[i].e_req);
            chk($sformatf("v%0d_stall", i), mem_stall_req, vt[i].e_stall);
            chk($sformatf("v%0d_misaligned", i), misaligned, vt[i].e_mis);
            chk($sformatf("v%0d_mis_addr", i), misaligned_addr, vt[i].e_mis ? vt[i].addr : 32'h0);
            chk($sformatf("v%0d_reg_write", i), wb.reg_write, vt[i].e_rw);
            chk($sformatf("v%0d_wb_valid", i), wb.valid, vt[i].valid);
            chk($sformatf("v%0d_alu_result", i), wb.alu_result, vt[i].addr);
            chk($sformatf("v%0d_mem_data", i), wb.mem_data, 32'h0);
            chk($sformatf("v%0d_pc", i), wb.pc, 32'h0000_1000);
            chk($sformatf("v%0d_wstrb", i), dmem_req_wstrb, vt[i].e_strb);
            if (vt[i].e_req) begin
                chk($sformatf("v%0d_we", i), dmem_req_we, 1'b1);
                chk($sformatf("v%0d_wdata", i), dmem_req_wdata, vt[i].e_wdata);
                chk($sformatf("v%0d_addr", i), dmem_req_addr, vt[i].e_addr);
            end
        end
        @(negedge ACLK); bubble();

        // LB with ready late by 2 cycles and the response 3 cycles after acceptance.
        n_stall = 0; n_req = 0;
        for (int c = 0; c < 7; c++) begin
            @(negedge ACLK);
            drive(1'b1, 1'b1, 1'b0, F3_B, 32'h203, 32'h0, 1'b1);
            dmem_req_ready = (c == 2);
            dmem_rsp_valid = (c == 6);
            dmem_rsp_rdata = (c == 6) ? 32'h80FF0000 : 32'h5A5A0000;
            #1;
            if (mem_stall_req) n_stall++;
            if (dmem_req_valid) begin
                n_req++;
                chk($sformatf("lb_req_addr_c%0d", c), dmem_req_addr, 32'h200);
                chk($sformatf("lb_req_we_c%0d", c), dmem_req_we, 1'b0);
            end
            if (c == 6) begin
                chk("lb_mem_data", wb.mem_data, 32'hFFFFFF80);
                chk("lb_reg_write", wb.reg_write, 1'b1);
            end
        end
        @(negedge ACLK); bubble();
        chk("lb_stall_cycles", n_stall, 6);
        chk("lb_req_cycles", n_req, 3);

        // Loads with immediate acceptance and a response on the next cycle.
        for (int i = 0; i < 5; i++) begin
            @(negedge ACLK);
            drive(1'b1, 1'b1, 1'b0, lt[i].f3, lt[i].addr, 32'h0, 1'b1);
            dmem_req_ready = 1'b1;
            #1;
            chk($sformatf("ld%0d_req_valid", i), dmem_req_valid, 1'b1);
            chk($sformatf("ld%0d_stall_req", i), mem_stall_req, 1'b1);
            @(negedge ACLK);
            dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b1; dmem_rsp_rdata = lt[i].rdata;
            #1;
            chk($sformatf("ld%0d_mem_data", i), wb.mem_data, lt[i].e_data);
            chk($sformatf("ld%0d_stall_rsp", i), mem_stall_req, 1'b0);
            @(negedge ACLK); bubble();
        end

        // LW completing under a 4-cycle external stall: one request, held result.
        n_req = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge ACLK);
            drive(1'b1, 1'b1, 1'b0, F3_W, 32'h300, 32'h0, 1'b1);
            stall_in = (c < 4);
            dmem_req_ready = 1'b1;
            dmem_rsp_valid = (c == 1);
            dmem_rsp_rdata = (c == 1) ? 32'hCAFEF00D : 32'h0BADBEEF;
            #1;
            if (dmem_req_valid && dmem_req_ready) n_req++;
            if (c >= 1) begin
                chk($sformatf("lwst_mem_data_c%0d", c), wb.mem_data, 32'hCAFEF00D);
                chk($sformatf("lwst_stall_c%0d", c), mem_stall_req, 1'b0);
            end
            if (c >= 2) chk($sformatf("lwst_state_c%0d", c), 32'(dut.state_r), 32'(DONE));
        end
        @(negedge ACLK); bubble(); #1;
        chk("lwst_state_end", 32'(dut.state_r), 32'(IDLE));
        chk("lwst_req_count", n_req, 1);

        // Reset while waiting for a response, then a stray response.
        @(negedge ACLK);
        drive(1'b1, 1'b1, 1'b0, F3_W, 32'h500, 32'h0, 1'b1);
        dmem_req_ready = 1'b1;
        @(negedge ACLK);
        ARESET = 1'b1; dmem_req_ready = 1'b0; #1;
        chk("mrst_state_before", 32'(dut.state_r), 32'(RSP));
        chk("mrst_req_valid", dmem_req_valid, 1'b0);
        chk("mrst_stall", mem_stall_req, 1'b0);
        chk("mrst_wb_bus", wb, '0);
        @(negedge ACLK);
        ARESET = 1'b0; bubble(); dmem_rsp_valid = 1'b1; dmem_rsp_rdata = 32'h11111111; #1;
        chk("stray_state", 32'(dut.state_r), 32'(IDLE));
        chk("stray_stall", mem_stall_req, 1'b0);
        chk("stray_mem_data", wb.mem_data, 32'h0);
        @(negedge ACLK); dmem_rsp_valid = 1'b0; #1;
        chk("stray_state_after", 32'(dut.state_r), 32'(IDLE));
        chk("stray_buf", dut.load_buf_r, 32'h0);
        drive(1'b1, 1'b1, 1'b0, F3_W, 32'h600, 32'h0, 1'b1);
        dmem_req_ready = 1'b1; #1;
        chk("post_req_valid", dmem_req_valid, 1'b1);
        chk("post_req_addr", dmem_req_addr, 32'h600);
        @(negedge ACLK);
        dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b1; dmem_rsp_rdata = 32'h24681357; #1;
        chk("post_mem_data", wb.mem_data, 32'h24681357);
        @(negedge ACLK); bubble();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the 5-stage RV32I pipeline, directly downstream of the EX/MEM pipeline register.
- Consumes ex_mem_bus_t and runs loads/stores through a valid/ready data-memory port, using a small load/store FSM.
- Aligns load data and sign/zero-extends it, then drives mem_wb_bus_t combinationally into the MEM/WB register.
- Raises mem_stall_req to the hazard unit until the access completes.

Parameters:
- XLEN, 32, datapath and address width; only 32 is supported.
- STRB_W, XLEN/8, number of byte-enable bits.

Ports:
- ACLK  in  1  clock.
- ARESET  in  1  synchronous, active-high reset.
- ex_mem_bus_in  in  ex_mem_bus_t  uses fields valid, alu_result (address), rs2_data, mem_read, mem_write, funct3, rd, reg_write, wb_sel, pc.
- stall_in  in  1  global pipeline stall from other causes; EX/MEM holds its contents while this is high.
- mem_stall_req  out  1  this stage needs the pipeline frozen.
- dmem_req_valid  out  1  request valid.
- dmem_req_ready  in  1  memory accepts the request.
- dmem_req_addr  out  XLEN  word-aligned address, {addr[31:2],2'b00}.
- dmem_req_we  out  1  1 = store.
- dmem_req_wstrb  out  STRB_W  byte enables.
- dmem_req_wdata  out  XLEN  lane-shifted store data.
- dmem_rsp_valid  in  1  load data valid.
- dmem_rsp_rdata  in  XLEN  load word.
- mem_wb_bus_out  out  mem_wb_bus_t  carries valid, mem_data, alu_result, rd, reg_write, wb_sel, pc.
- misaligned  out  1  misaligned-access pulse.
- misaligned_addr  out  XLEN  faulting address.

Behaviour:
- Reset (synchronous, ARESET=1 at a rising ACLK edge):
  - FSM goes to IDLE; load buffer clears to 0.
  - All outputs read 0 while reset is held: dmem_req_valid, mem_stall_req, misaligned, mem_wb_bus_out.
  - Reset mid-transaction abandons the access. A dmem_rsp_valid arriving with no access pending (IDLE/DONE) is ignored.
- access = in.valid & (mem_read | mem_write).
- Alignment rules:
  - Halfword: addr[0] must be 0.
  - Word: addr[1:0] must be 00.
  - Misaligned access: no request is issued. misaligned=1 and misaligned_addr=addr for every cycle the instruction is presented in IDLE. mem_wb_bus_out.reg_write is forced to 0 and no stall is raised.
- FSM states: IDLE, REQ, RSP, DONE.
  - IDLE:
    - Asserts dmem_req_valid combinationally when there is an aligned access.
    - On handshake: a store goes to DONE if stall_in=1, else stays in IDLE (no stall, 0-cycle). A load goes to RSP.
    - No handshake: go to REQ, mem_stall_req=1.
  - REQ:
    - Holds dmem_req_valid and all request fields stable until ready; mem_stall_req=1.
    - On handshake: a store completes (mem_stall_req drops that cycle), then goes to DONE if stall_in=1, else IDLE. A load goes to RSP.
  - RSP:
    - mem_stall_req=1 until dmem_rsp_valid. In the response cycle the extracted data drives mem_data directly and mem_stall_req=0.
    - The data is latched into the buffer. Next state is DONE if stall_in=1, else IDLE.
  - DONE:
    - Holds the completed result with no re-request; mem_data comes from the buffer; mem_stall_req=0.
    - Returns to IDLE on the first cycle stall_in=0, because the instruction advances that edge.
- A load response arriving in the same cycle as request acceptance is not permitted; memory latency is at least 1 cycle after the handshake.
- Store encoding (funct3):
  - SB: wstrb=0001<<addr[1:0], wdata=rs2[7:0] replicated ×4.
  - SH: wstrb=0011<<addr[1:0], wdata=rs2[15:0] replicated ×2.
  - SW: wstrb=1111.
- Load extraction from the rdata lane at addr[1:0]:
  - LB/LH are sign-extended; LBU/LHU are zero-extended; LW is passed through.
  - An unknown funct3 is treated as LW/SW.
- Passthrough and bubbles:
  - Non-memory instructions pass alu_result, rd, reg_write, wb_sel and pc through combinationally, with mem_data=0.
  - in.valid=0 produces a bubble: mem_wb_bus_out.valid=0, no request, no stall.

Decomposition:
- CPU_buffer_bus gains mem_wb_bus_t (if it is absent) and enum lsu_state_e {IDLE,REQ,RSP,DONE}.
- A shared package holds the funct3 constants F3_B/H/W/BU/HU.
- One natural sub-module, lsu_align: purely combinational store-lane/wstrb generation, load extraction/extension, and the misalign check.

Test Plan:
- SW addr=0x104, rs2=0xDEADBEEF, ready=1 immediately → one-cycle req: addr=0x104, wstrb=1111, wdata=0xDEADBEEF, we=1; mem_stall_req never 1.
- LB addr=0x203 with ready delayed 2 cycles, rsp 3 cycles later carrying rdata=0x80FF_0000 → req held stable for 3 cycles, stall for 6 cycles total, mem_data=0xFFFFFF80.
- LHU addr=0x202, rdata=0x80FF1234 → mem_data=0x000080FF. SH addr=0x102, rs2=0xAAAA5555 → wstrb=1100, wdata=0x55555555.
- LW completes while stall_in=1 held for 4 cycles → exactly one dmem request, FSM stays in DONE, mem_data stays constant until stall_in drops.
- LW addr=0x101 → no dmem_req_valid, misaligned=1, misaligned_addr=0x101, reg_write=0, no stall.
- ARESET asserted in RSP, then a stray dmem_rsp_valid the next cycle → all outputs 0, FSM IDLE, response ignored, next access issues normally.
